// File: rtl/vmw_bist_ctrl_if.sv
// Bus between the BIST controller and its environment: run control, the
// stimulus/response path to the VMW cell netlist, and the result.
interface vmw_bist_ctrl_if;
  logic        START;
  logic [7:0]  NPAT;
  logic [15:0] GOLD;
  logic [3:0]  RESP;
  logic [7:0]  PAT;
  logic [15:0] SIG;
  logic        BUSY;
  logic        DONE;
  logic        PASS;

  // Environment side: requests runs, returns cell responses.
  modport master (
    output START, NPAT, GOLD, RESP,
    input  PAT, SIG, BUSY, DONE, PASS
  );

  // Controller side.
  modport slave (
    input  START, NPAT, GOLD, RESP,
    output PAT, SIG, BUSY, DONE, PASS
  );
endinterface

// File: rtl/vmw_bist_ctrl.sv
// BIST controller: drives an 8-bit LFSR pattern stream into the cell under
// test, compacts the 4-bit responses into a 16-bit MISR and compares the
// final signature against a golden value.
module vmw_bist_ctrl #(
  parameter logic [7:0]  SEED = 8'h01,
  parameter int unsigned LAT  = 1
) (
  input logic            CP,
  input logic            CLRN,
  vmw_bist_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StCheck} state_e;

  // Last DRAIN cycle index; unused when LAT is 0.
  localparam logic [1:0] DrainLast = 2'(LAT - 1);

  state_e      state_q, state_d;
  logic [7:0]  pat_q, pat_d;
  logic [7:0]  npat_q, npat_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  dcnt_q, dcnt_d;
  logic [15:0] sig_q, sig_d;
  logic        pass_q, pass_d;
  logic        last_pat;
  logic        comp;
  logic [7:0]  pat_next;
  logic [15:0] sig_next;

  // An NPAT of 0 wraps to 8'hff here, giving 256 patterns.
  assign last_pat = (state_q == StRun) && (cnt_q == npat_q - 8'd1);
  assign pat_next = {pat_q[6:0], pat_q[7] ^ pat_q[5] ^ pat_q[4] ^ pat_q[3]};
  assign sig_next = {sig_q[14:0], sig_q[15] ^ sig_q[11] ^ sig_q[4]} ^ {12'b0, bus.RESP};

  // Compaction-valid: RESP for a pattern arrives LAT cycles after it is applied.
  if (LAT == 0) begin : g_vld_comb
    assign comp = (state_q == StRun);
  end else begin : g_vld_pipe
    logic [LAT-1:0] vld_q, vld_d;

    // Shift in one valid bit per RUN cycle.
    always_comb begin
      vld_d    = vld_q << 1;
      vld_d[0] = (state_q == StRun);
    end

    // Valid pipeline register, flushed by reset.
    always_ff @(posedge CP) begin
      if (!CLRN) vld_q <= '0;
      else       vld_q <= vld_d;
    end

    assign comp = vld_q[LAT-1];
  end

  // Next-state, pattern generation, compaction and result capture.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    npat_d  = npat_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle: begin
        pat_d = SEED;
        if (bus.START) begin
          state_d = StRun;
          npat_d  = bus.NPAT;
          cnt_d   = '0;
          dcnt_d  = '0;
          sig_d   = '0;
          pass_d  = 1'b0;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 8'd1;
        // PAT stays on the last applied pattern through DRAIN and CHECK.
        if (last_pat) state_d = (LAT == 0) ? StCheck : StDrain;
        else          pat_d   = pat_next;
      end
      StDrain: begin
        dcnt_d = dcnt_q + 2'd1;
        if (dcnt_q == DrainLast) state_d = StCheck;
      end
      StCheck: begin
        pass_d  = (sig_q == bus.GOLD);
        pat_d   = SEED;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Never set while IDLE, so it cannot collide with the START clear.
    if (comp) sig_d = sig_next;
  end

  // State register with synchronous abort-to-idle reset.
  always_ff @(posedge CP) begin
    if (!CLRN) begin
      state_q <= StIdle;
      pat_q   <= SEED;
      npat_q  <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      sig_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      npat_q  <= npat_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.PAT  = pat_q;
  assign bus.SIG  = sig_q;
  assign bus.BUSY = (state_q != StIdle);
  assign bus.DONE = (state_q == StCheck);
  assign bus.PASS = pass_q;

endmodule
